// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with registered one-hot grant and a single idle cycle between owners.
// Optional forced release after HOLD_MAX owned cycles when RR_ARBITER8_TIMEOUT_EN is defined.
`timescale 1ns/1ps

module rr_arbiter8 #(
   parameter int HOLD_MAX = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   input  logic       done,
   output logic [7:0] grant,
   output logic [2:0] grant_idx,
   output logic       busy,
   output logic       timeout,
   output logic       state_dbg
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_OWN  = 1'b1
   } state_t;

   state_t     r_state;
   logic [7:0] r_grant;
   logic [2:0] r_grant_idx;
   logic       r_timeout;

   state_t     w_state_nxt;
   logic [7:0] w_grant_nxt;
   logic [2:0] w_idx_nxt;
   logic       w_timeout_nxt;
   logic [2:0] w_cand;
   logic [2:0] w_sel_idx;
   logic       w_found;
   logic       w_release;

   generate
      if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
         $error("rr_arbiter8: HOLD_MAX must be in 1..255");
      end
   endgenerate

`ifdef RR_ARBITER8_TIMEOUT_EN
   logic [7:0] r_hold_cnt;
   logic [7:0] w_hold_cnt_nxt;
   logic       w_hold_hit;

   assign w_hold_hit = ((r_hold_cnt + 8'd1) == 8'(HOLD_MAX));
`endif

   // Search upward from the slot after the last owner; the last owner itself is tried last.
   always_comb begin
      w_sel_idx = r_grant_idx;
      w_found   = 1'b0;
      w_cand    = r_grant_idx;
      for (int i = 1; i <= 8; i++) begin
         w_cand = r_grant_idx + 3'(i);
         if (!w_found && req[w_cand]) begin
            w_found   = 1'b1;
            w_sel_idx = w_cand;
         end
      end
   end

   assign w_release = done | ~req[r_grant_idx];

   always_comb begin
      w_state_nxt   = r_state;
      w_grant_nxt   = r_grant;
      w_idx_nxt     = r_grant_idx;
      w_timeout_nxt = 1'b0;
`ifdef RR_ARBITER8_TIMEOUT_EN
      w_hold_cnt_nxt = r_hold_cnt;
`endif
      case (r_state)
         ST_IDLE: begin
            w_grant_nxt = 8'h00;
            if (w_found) begin
               w_state_nxt = ST_OWN;
               w_grant_nxt = 8'h01 << w_sel_idx;
               w_idx_nxt   = w_sel_idx;
`ifdef RR_ARBITER8_TIMEOUT_EN
               w_hold_cnt_nxt = 8'd0;
`endif
            end
         end
         ST_OWN: begin
            if (w_release) begin
               w_state_nxt = ST_IDLE;
               w_grant_nxt = 8'h00;
            end
`ifdef RR_ARBITER8_TIMEOUT_EN
            // A genuine release on the limit edge wins, so no timeout pulse then.
            else if (w_hold_hit) begin
               w_state_nxt   = ST_IDLE;
               w_grant_nxt   = 8'h00;
               w_timeout_nxt = 1'b1;
            end else begin
               w_hold_cnt_nxt = r_hold_cnt + 8'd1;
            end
`endif
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_grant_nxt = 8'h00;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_grant     <= 8'h00;
         r_grant_idx <= 3'd7;
         r_timeout   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_grant     <= w_grant_nxt;
         r_grant_idx <= w_idx_nxt;
         r_timeout   <= w_timeout_nxt;
      end
   end

`ifdef RR_ARBITER8_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hold_cnt <= 8'd0;
      end else begin
         r_hold_cnt <= w_hold_cnt_nxt;
      end
   end
`endif

   assign grant     = r_grant;
   assign grant_idx = r_grant_idx;
   assign busy      = |r_grant;
   assign timeout   = r_timeout;
   assign state_dbg = r_state;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8: expected outputs are queued as each step is driven and
// popped/compared one ns after the following rising edge.
`timescale 1ns/1ps

module tb_rr_arbiter8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] req;
   logic       done;
   logic [7:0] grant;
   logic [2:0] grant_idx;
   logic       busy;
   logic       timeout;
   logic       state_dbg;

   int checks = 0;
   int errors = 0;

   // {grant[7:0], grant_idx[2:0], busy, timeout}
   logic [12:0] exp_q[$];

   always #5 clk = ~clk;

   rr_arbiter8 #(.HOLD_MAX(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .done      (done),
      .grant     (grant),
      .grant_idx (grant_idx),
      .busy      (busy),
      .timeout   (timeout),
      .state_dbg (state_dbg)
   );

   task automatic check8(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic compare_out(input string tag);
      logic [12:0] e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s: observed empty queue expected an entry", tag);
      end else begin
         e = exp_q.pop_front();
         check8({tag, ".grant"},     grant,                  e[12:5]);
         check8({tag, ".grant_idx"}, {5'b0, grant_idx},      {5'b0, e[4:2]});
         check8({tag, ".busy"},      {7'b0, busy},           {7'b0, e[1]});
         check8({tag, ".timeout"},   {7'b0, timeout},        {7'b0, e[0]});
         check8({tag, ".state"},     {7'b0, state_dbg},      {7'b0, e[1]});
      end
   endtask

   task automatic step(input string tag, input logic [7:0] t_req, input logic t_done,
                       input logic [7:0] e_grant, input logic [2:0] e_idx, input logic e_to);
      req  = t_req;
      done = t_done;
      exp_q.push_back({e_grant, e_idx, |e_grant, e_to});
      @(posedge clk);
      #1;
      compare_out(tag);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed no finish expected finish before 100000ns");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      req   = 8'h00;
      done  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      exp_q.push_back({8'h00, 3'd7, 1'b0, 1'b0});
      compare_out("reset");
      rst_n = 1'b1;

      // single requester, release by done, done ignored while idle
      step("first_grant", 8'h01, 1'b0, 8'h01, 3'd0, 1'b0);
      step("done_release", 8'h01, 1'b1, 8'h00, 3'd0, 1'b0);
      step("idle_no_req", 8'h00, 1'b0, 8'h00, 3'd0, 1'b0);
      step("idle_done", 8'h00, 1'b1, 8'h00, 3'd0, 1'b0);

      // all requesting, done held high: rotate through every index and wrap 7->0
      for (int k = 0; k < 9; k++) begin
         int ix;
         ix = (1 + k) % 8;
         step("rr_grant", 8'hFF, 1'b1, 8'h01 << ix, 3'(ix), 1'b0);
         step("rr_gap", 8'hFF, 1'b1, 8'h00, 3'(ix), 1'b0);
      end

      // owner 3 holds against other requests, then drops its own request
      step("own3", 8'h08, 1'b0, 8'h08, 3'd3, 1'b0);
      step("own3_hold_a", 8'hFF, 1'b0, 8'h08, 3'd3, 1'b0);
      step("own3_hold_b", 8'hFF, 1'b0, 8'h08, 3'd3, 1'b0);
      step("own3_req_drop", 8'hF7, 1'b0, 8'h00, 3'd3, 1'b0);

      // owner 5 with req 21: next goes to 0, then back to 5
      step("own5", 8'h21, 1'b0, 8'h20, 3'd5, 1'b0);
      step("own5_rel", 8'h21, 1'b1, 8'h00, 3'd5, 1'b0);
      step("after5_is0", 8'h21, 1'b0, 8'h01, 3'd0, 1'b0);
      step("own0_rel", 8'h21, 1'b1, 8'h00, 3'd0, 1'b0);
      step("back_to5", 8'h21, 1'b0, 8'h20, 3'd5, 1'b0);
      step("back5_rel", 8'h21, 1'b1, 8'h00, 3'd5, 1'b0);
      step("fair6", 8'h60, 1'b0, 8'h40, 3'd6, 1'b0);
      step("fair6_rel", 8'h60, 1'b1, 8'h00, 3'd6, 1'b0);
      step("fair5", 8'h60, 1'b0, 8'h20, 3'd5, 1'b0);
      step("fair5_rel", 8'h20, 1'b1, 8'h00, 3'd5, 1'b0);
      step("self_regain", 8'h20, 1'b0, 8'h20, 3'd5, 1'b0);
      step("self_drop", 8'h00, 1'b0, 8'h00, 3'd5, 1'b0);
      step("idle_hold_idx", 8'h00, 1'b0, 8'h00, 3'd5, 1'b0);

`ifdef RR_ARBITER8_TIMEOUT_EN
      step("to_grant", 8'h04, 1'b0, 8'h04, 3'd2, 1'b0);
      for (int k = 0; k < 3; k++) step("to_hold", 8'h04, 1'b0, 8'h04, 3'd2, 1'b0);
      step("to_pulse", 8'h04, 1'b0, 8'h00, 3'd2, 1'b1);
      step("to_regrant", 8'h04, 1'b0, 8'h04, 3'd2, 1'b0);
      for (int k = 0; k < 3; k++) step("to_hold2", 8'h04, 1'b0, 8'h04, 3'd2, 1'b0);
      step("to_rel_wins", 8'h04, 1'b1, 8'h00, 3'd2, 1'b0);
`else
      step("long_grant", 8'h02, 1'b0, 8'h02, 3'd1, 1'b0);
      for (int k = 0; k < 20; k++) step("long_hold", 8'h02, 1'b0, 8'h02, 3'd1, 1'b0);
      step("long_rel", 8'h02, 1'b1, 8'h00, 3'd1, 1'b0);
`endif

      // asynchronous reset while owner 4 holds the grant
      step("own4", 8'h10, 1'b0, 8'h10, 3'd4, 1'b0);
      rst_n = 1'b0;
      #2;
      exp_q.push_back({8'h00, 3'd7, 1'b0, 1'b0});
      compare_out("async_reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step("post_reset_grant", 8'h10, 1'b0, 8'h10, 3'd4, 1'b0);
      step("post_reset_rel", 8'h10, 1'b1, 8'h00, 3'd4, 1'b0);

      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $error("FAIL queue_drain: observed %0d entries expected 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
